// File: rtl/rc_pkg.sv
// Shared state encoding and handshake polarities for the region-reconfiguration initiator.
package rc_pkg;

    typedef enum logic [2:0] {
        RC_IDLE = 3'd0,
        RC_REQ  = 3'd1,
        RC_LOAD = 3'd2,
        RC_REL  = 3'd3,
        RC_DONE = 3'd4
    } rc_state_t;

    // Both region handshake lines are active-low.
    localparam logic RC_REQ_ASSERT = 1'b0;
    localparam logic RC_ACK_ASSERT = 1'b0;

    // States in which the region request is held asserted.
    function automatic logic rc_req_active(input rc_state_t s);
        return (s == RC_REQ) || (s == RC_LOAD);
    endfunction

    // States that wait on the region acknowledge and are therefore timed.
    function automatic logic rc_ack_wait(input rc_state_t s);
        return (s == RC_REQ) || (s == RC_REL);
    endfunction

endpackage

// File: rtl/rc_tmo_cnt.sv
// Acknowledge-timeout counter: cleared on entry to a waiting state, counts while en,
// and flags hit during the TMO_CYC-th enabled cycle after the clear.
module rc_tmo_cnt #(
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // Saturates at LAST so a stalled count never wraps back to a non-hit value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = en && (cnt_q == LAST);

endmodule

// File: rtl/rc_initiator.sv
// Region-reconfiguration initiator: requests a region, starts the configuration engine,
// then releases the region. Define RC_TIMEOUT_EN to add the acknowledge timeout and err flag.
module rc_initiator
    import rc_pkg::*;
#(
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = 1000
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    input  logic      rc_ackn,
    input  logic      cfg_done,
    output logic      rc_reqn,
    output logic      cfg_go,
    output logic      busy,
    output logic      err,
    output rc_state_t state_dbg
);

    if ((TMO_W < 1) || (TMO_CYC < 1) ||
        (longint'(TMO_CYC) >= (longint'(1) << TMO_W))) begin : g_bad_tmo
        $error("rc_initiator: TMO_CYC must lie in 1 .. 2**TMO_W-1");
    end

    rc_state_t state_q;
    rc_state_t state_d;
    logic      rc_reqn_q;
    logic      rc_reqn_d;
    logic      cfg_go_q;
    logic      cfg_go_d;
    logic      ack_low;
    logic      tmo_hit;

    assign ack_low = (rc_ackn == RC_ACK_ASSERT);

    // Four-phase region handshake: rc_reqn falls, wait for rc_ackn low, load, raise
    // rc_reqn, wait for rc_ackn high. Each edge is acted on once, in the state waiting for it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RC_IDLE: begin
                if (start) state_d = RC_REQ;
            end
            RC_REQ: begin
                if (ack_low)      state_d = RC_LOAD;
                else if (tmo_hit) state_d = RC_IDLE;
            end
            RC_LOAD: begin
                if (cfg_done) state_d = RC_REL;
            end
            RC_REL: begin
                if (!ack_low)     state_d = RC_DONE;
                else if (tmo_hit) state_d = RC_IDLE;
            end
            RC_DONE: begin
                state_d = RC_IDLE;
            end
            default: begin
                state_d = RC_IDLE;
            end
        endcase

        rc_reqn_d = rc_req_active(state_d) ? RC_REQ_ASSERT : ~RC_REQ_ASSERT;
        cfg_go_d  = (state_q == RC_REQ) && (state_d == RC_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RC_IDLE;
            rc_reqn_q <= ~RC_REQ_ASSERT;
            cfg_go_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rc_reqn_q <= rc_reqn_d;
            cfg_go_q  <= cfg_go_d;
        end
    end

`ifdef RC_TIMEOUT_EN
    logic tmo_clr;
    logic tmo_en;
    logic err_q;
    logic err_d;

    assign tmo_en  = rc_ack_wait(state_q);
    assign tmo_clr = (state_d != state_q) && rc_ack_wait(state_d);

    rc_tmo_cnt #(
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk (clk),
        .rst (rst),
        .clr (tmo_clr),
        .en  (tmo_en),
        .hit (tmo_hit)
    );

    // A genuine acknowledge in the hit cycle wins, so err only sets on an actual abort.
    always_comb begin
        err_d = err_q;
        if ((state_q == RC_IDLE) && start) begin
            err_d = 1'b0;
        end else if (tmo_hit && (state_d == RC_IDLE)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    assign rc_reqn   = rc_reqn_q;
    assign cfg_go    = cfg_go_q;
    assign busy      = (state_q != RC_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_rc_initiator.sv
// Directed bench for rc_initiator: the driver queues expected output events with their
// cycle stamps, and a negedge monitor compares every output change against that queue.
module tb_rc_initiator;
    import rc_pkg::*;

    localparam int W = 24;

    logic      clk      = 1'b0;
    logic      rst      = 1'b1;
    logic      start    = 1'b0;
    logic      rc_ackn  = 1'b1;
    logic      cfg_done = 1'b0;
    logic      rc_reqn;
    logic      cfg_go;
    logic      busy;
    logic      err;
    rc_state_t state_dbg;

    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic [6:0]  prev_v;
    logic [W-1:0] exp_q[$];

    rc_initiator #(
        .TMO_W   (16),
        .TMO_CYC (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rc_ackn   (rc_ackn),
        .cfg_done  (cfg_done),
        .rc_reqn   (rc_reqn),
        .cfg_go    (cfg_go),
        .busy      (busy),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Clock and cycle stamp: after posedge k, cyc == k.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got time limit reached, expected run to finish");
        $fatal(1, "watchdog");
    end

    // Event word: {cycle[15:0], 0, cfg_go, rc_reqn, busy, err, state[2:0]}.
    function automatic logic [W-1:0] mk_ev(input int unsigned c, input logic go,
                                           input logic reqn, input logic bsy,
                                           input logic e, input rc_state_t st);
        logic [15:0] c16;
        c16 = c[15:0];
        return {c16, 1'b0, go, reqn, bsy, e, st};
    endfunction

    // Monitor: any change of the output vector is an event that must match the queue head.
    always @(negedge clk) begin
        logic [6:0]   cur_v;
        logic [W-1:0] got;
        logic [W-1:0] exp;
        cur_v = {cfg_go, rc_reqn, busy, err, state_dbg};
        if (mon_en && (cur_v !== prev_v)) begin
            checks++;
            got = {cyc[15:0], 1'b0, cur_v};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got cyc=%0d vec=%b, expected no event", cyc, cur_v);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d vec=%b, expected cyc=%0d vec=%b",
                             got[23:8], got[6:0], exp[23:8], exp[6:0]);
                end
            end
        end
        prev_v = cur_v;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full handshake. extra: 0 none, 1 start during LOAD, 2 start during DONE,
    // 3 stray cfg_done during REQ (needs ack_dly >= 2).
    task automatic run_seq(input int ack_dly, input int done_dly, input int rel_dly, input int extra);
        start = 1'b1;
        exp_q.push_back(mk_ev(cyc + 1, 1'b0, 1'b0, 1'b1, 1'b0, RC_REQ));
        step(1);
        start = 1'b0;
        if (extra == 3) begin
            cfg_done = 1'b1;
            step(1);
            cfg_done = 1'b0;
            step(ack_dly - 1);
        end else begin
            step(ack_dly);
        end
        rc_ackn = 1'b0;
        exp_q.push_back(mk_ev(cyc + 1, 1'b1, 1'b0, 1'b1, 1'b0, RC_LOAD));
        exp_q.push_back(mk_ev(cyc + 2, 1'b0, 1'b0, 1'b1, 1'b0, RC_LOAD));
        step(1);
        if (extra == 1) begin
            step(2);
            start = 1'b1;
            step(1);
            start = 1'b0;
            step(done_dly - 3);
        end else begin
            step(done_dly);
        end
        cfg_done = 1'b1;
        exp_q.push_back(mk_ev(cyc + 1, 1'b0, 1'b1, 1'b1, 1'b0, RC_REL));
        step(1);
        cfg_done = 1'b0;
        step(rel_dly);
        rc_ackn = 1'b1;
        exp_q.push_back(mk_ev(cyc + 1, 1'b0, 1'b1, 1'b1, 1'b0, RC_DONE));
        exp_q.push_back(mk_ev(cyc + 2, 1'b0, 1'b1, 1'b0, 1'b0, RC_IDLE));
        step(1);
        if (extra == 2) begin
            start = 1'b1;
            step(1);
            start = 1'b0;
        end
        step(3);
    endtask

    initial begin
        // Reset state
        step(3);
        check("rst_reqn", 32'(rc_reqn), 32'd1);
        check("rst_go", 32'(cfg_go), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(RC_IDLE));
        mon_en = 1'b1;
        rst    = 1'b0;
        step(2);

        // Nominal handshake, then start dropped in LOAD and in DONE
        run_seq(3, 10, 2, 0);
        run_seq(3, 10, 2, 1);
        run_seq(1, 4, 1, 2);

        // Stray rc_ackn low in IDLE, stray cfg_done in REQ
        rc_ackn = 1'b0;
        step(4);
        rc_ackn = 1'b1;
        step(2);
        run_seq(3, 5, 2, 3);

        // Reset mid-LOAD: immediate release, then a clean run
        start = 1'b1;
        exp_q.push_back(mk_ev(cyc + 1, 1'b0, 1'b0, 1'b1, 1'b0, RC_REQ));
        step(1);
        start = 1'b0;
        step(2);
        rc_ackn = 1'b0;
        exp_q.push_back(mk_ev(cyc + 1, 1'b1, 1'b0, 1'b1, 1'b0, RC_LOAD));
        exp_q.push_back(mk_ev(cyc + 2, 1'b0, 1'b0, 1'b1, 1'b0, RC_LOAD));
        step(3);
        rst = 1'b1;
        exp_q.push_back(mk_ev(cyc, 1'b0, 1'b1, 1'b0, 1'b0, RC_IDLE));
        #1;
        check("rst_load_reqn", 32'(rc_reqn), 32'd1);
        check("rst_load_busy", 32'(busy), 32'd0);
        step(1);
        rc_ackn = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);
        run_seq(3, 10, 2, 0);

        // Reset in REQ with the ack arriving: no cfg_go may follow
        start = 1'b1;
        exp_q.push_back(mk_ev(cyc + 1, 1'b0, 1'b0, 1'b1, 1'b0, RC_REQ));
        step(1);
        start = 1'b0;
        step(1);
        rc_ackn = 1'b0;
        rst     = 1'b1;
        exp_q.push_back(mk_ev(cyc, 1'b0, 1'b1, 1'b0, 1'b0, RC_IDLE));
        step(2);
        rc_ackn = 1'b1;
        rst     = 1'b0;
        step(3);

`ifdef RC_TIMEOUT_EN
        // REQ timeout after exactly 8 REQ cycles, then the next start clears err
        start = 1'b1;
        exp_q.push_back(mk_ev(cyc + 1, 1'b0, 1'b0, 1'b1, 1'b0, RC_REQ));
        exp_q.push_back(mk_ev(cyc + 9, 1'b0, 1'b1, 1'b0, 1'b1, RC_IDLE));
        step(1);
        start = 1'b0;
        step(12);
        check("tmo_req_err", 32'(err), 32'd1);
        run_seq(3, 10, 2, 0);

        // REL timeout: ack never released
        start = 1'b1;
        exp_q.push_back(mk_ev(cyc + 1, 1'b0, 1'b0, 1'b1, 1'b0, RC_REQ));
        step(1);
        start = 1'b0;
        step(2);
        rc_ackn = 1'b0;
        exp_q.push_back(mk_ev(cyc + 1, 1'b1, 1'b0, 1'b1, 1'b0, RC_LOAD));
        exp_q.push_back(mk_ev(cyc + 2, 1'b0, 1'b0, 1'b1, 1'b0, RC_LOAD));
        step(3);
        cfg_done = 1'b1;
        exp_q.push_back(mk_ev(cyc + 1, 1'b0, 1'b1, 1'b1, 1'b0, RC_REL));
        exp_q.push_back(mk_ev(cyc + 9, 1'b0, 1'b1, 1'b0, 1'b1, RC_IDLE));
        step(1);
        cfg_done = 1'b0;
        step(11);
        rc_ackn = 1'b1;
        step(2);
        run_seq(2, 3, 1, 0);
`else
        // No timeout: REQ waits indefinitely
        start = 1'b1;
        exp_q.push_back(mk_ev(cyc + 1, 1'b0, 1'b0, 1'b1, 1'b0, RC_REQ));
        step(1);
        start = 1'b0;
        step(5000);
        check("stall_reqn", 32'(rc_reqn), 32'd0);
        check("stall_err", 32'(err), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_state", 32'(state_dbg), 32'(RC_REQ));
        rst = 1'b1;
        exp_q.push_back(mk_ev(cyc, 1'b0, 1'b1, 1'b0, 1'b0, RC_IDLE));
        step(2);
        rst = 1'b0;
        step(2);
        run_seq(3, 10, 2, 0);
`endif

        step(5);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
